// File: rtl/dco_nco_gen2.sv
// Phase-accumulator DCO with a valid/ready code-update handshake, wrap-aligned
// (direct or slew-limited) code switching and a gated edge counter for self-test.
module dco_nco_gen2 #(
  parameter int ACC_W      = 8,
  parameter int CODE_W     = 8,
  parameter int OFFSET     = 1,
  parameter int STEP       = 4,
  parameter int RESET_CODE = 0,
  parameter int GATE_CYC   = 256,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [1:0]        mode,
  output logic              dco_out,
  output logic [CODE_W-1:0] active_code,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_valid
);

  localparam int             GATE_W    = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [ACC_W:0] NYQ       = (ACC_W+1)'(1) << (ACC_W - 1);
  localparam logic [1:0]     MODE_SLEW   = 2'b01;
  localparam logic [1:0]     MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PEND = 2'b01,
    S_DONE = 2'b10
  } hs_state_t;

  hs_state_t           state, state_next;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W:0]      inc;
  logic [ACC_W:0]      sum;
  logic                wrap_en;
  logic                rise;
  logic [CODE_W-1:0]   target;
  logic [CODE_W-1:0]   code_next;
  logic                apply;
  logic                reached;
  logic                accept;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;

  // Phase increment limited to half the accumulator range (Nyquist).
  function automatic logic [ACC_W:0] clamp_inc(input logic [CODE_W-1:0] code);
    logic [ACC_W:0] raw;
    raw = (ACC_W+1)'(code) + (ACC_W+1)'(OFFSET);
    return (raw > NYQ) ? NYQ : raw;
  endfunction

  function automatic logic [CODE_W-1:0] slew_next(input logic [CODE_W-1:0] cur,
                                                  input logic [CODE_W-1:0] tgt);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > STEP)
      return CODE_W'(int'(cur) + STEP);
    else if (d < -STEP)
      return CODE_W'(int'(cur) - STEP);
    else
      return tgt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    inc     = clamp_inc(active_code);
    sum     = {1'b0, acc} + inc;
    wrap_en = ena && sum[ACC_W];
    rise    = ena && !dco_out && sum[ACC_W-1];
  end

  // Codes only change on a wrap so the output never produces a runt pulse.
  always_comb begin
    apply     = (state == S_PEND) && wrap_en && (mode != MODE_FREEZE);
    code_next = (mode == MODE_SLEW) ? slew_next(active_code, target) : target;
    reached   = (code_next == target);
    accept    = code_valid && code_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_PEND;
      S_PEND:  if (apply && reached) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    code_ready = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      dco_out <= 1'b0;
    end else if (ena) begin
      acc     <= sum[ACC_W-1:0];
      dco_out <= sum[ACC_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      target <= '0;
    else if (accept)
      target <= code_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      active_code <= CODE_W'(RESET_CODE);
    else if (apply)
      active_code <= code_next;
  end

  // Gate window: the rising edge landing on the last gate cycle still counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else if (!ena) begin
      meas_valid <= 1'b0;
    end else if (gate_cnt == GATE_LAST) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      meas_count <= rise ? sat_inc(edge_cnt) : edge_cnt;
      meas_valid <= 1'b1;
    end else begin
      gate_cnt   <= gate_cnt + 1'b1;
      if (rise)
        edge_cnt <= sat_inc(edge_cnt);
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dco_nco_gen2.sv
// Bench for dco_nco_gen2: reset/table vectors, directed handshake, slew, freeze
// and ena sequences, then random traffic against a cycle-level arithmetic model.
module tb_dco_nco_gen2;

  logic       clk = 1'b0;
  logic       rst_n, ena, code_valid, code_ready, dco_out, meas_valid;
  logic [7:0] code_in, active_code;
  logic [1:0] mode;
  logic [15:0] meas_count;

  always #5 clk = ~clk;

  dco_nco_gen2 #(.ACC_W(8), .CODE_W(8), .OFFSET(1), .STEP(4), .RESET_CODE(0),
                 .GATE_CYC(256), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .mode(mode), .dco_out(dco_out), .active_code(active_code),
    .meas_count(meas_count), .meas_valid(meas_valid));

  int n_pass = 0;
  int n_total = 0;
  int edge_no = 0;

  // Reference model: phase in 0..255, pending codes in a queue.
  int m_phase, m_active, m_gate, m_edges, m_mc;
  bit m_mv, m_rel;
  int m_q[$];

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  function automatic int m_ready();
    return (m_q.size() == 0 && !m_rel) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int inc, tot, np, t, d;
    bit acc_ok, rise, wrap;
    if (!rst_n) begin
      m_phase = 0; m_active = 0; m_gate = 0; m_edges = 0; m_mc = 0;
      m_mv = 0; m_rel = 0; m_q.delete();
      return;
    end
    acc_ok = code_valid && (m_ready() == 1);
    m_rel = 0;
    if (ena) begin
      inc = m_active + 1;
      if (inc > 128) inc = 128;
      tot  = m_phase + inc;
      wrap = (tot >= 256);
      np   = tot % 256;
      rise = (m_phase < 128) && (np >= 128);
      if (wrap && m_q.size() > 0 && mode != 2'd2) begin
        t = m_q[0];
        if (mode == 2'd1) begin
          d = t - m_active;
          if (d > 4) d = 4;
          else if (d < -4) d = -4;
          m_active += d;
        end else begin
          m_active = t;
        end
        if (m_active == t) begin
          void'(m_q.pop_front());
          m_rel = 1;
        end
      end
      if (m_gate == 255) begin
        m_mc = m_edges + int'(rise);
        if (m_mc > 65535) m_mc = 65535;
        m_edges = 0; m_gate = 0; m_mv = 1;
      end else begin
        m_edges += int'(rise);
        if (m_edges > 65535) m_edges = 65535;
        m_gate++; m_mv = 0;
      end
      m_phase = np;
    end else begin
      m_mv = 0;
    end
    if (acc_ok) m_q.push_back(int'(code_in));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_no++;
    #1;
    check("dco_out", int'(dco_out), (m_phase >= 128) ? 1 : 0);
    check("active_code", int'(active_code), m_active);
    check("code_ready", int'(code_ready), m_ready());
    check("meas_count", int'(meas_count), m_mc);
    check("meas_valid", int'(meas_valid), int'(m_mv));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic send_code(input int c);
    int k = 0;
    while (!code_ready && k < 3000) begin step(); k++; end
    check("send_ready_timeout", int'(code_ready), 1);
    code_in = 8'(c);
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("ready_drop_after_accept", int'(code_ready), 0);
  endtask

  task automatic wait_active_change(output int val);
    int prev = int'(active_code);
    int k = 0;
    while (int'(active_code) == prev && k < 3000) begin step(); k++; end
    if (k >= 3000) check("active_change_timeout", k, 0);
    val = int'(active_code);
  endtask

  task automatic wait_mv();
    int k = 0;
    step();
    while (!meas_valid && k < 3000) begin step(); k++; end
    if (k >= 3000) check("meas_valid_timeout", k, 0);
  endtask

  typedef struct {
    int edges;
    bit exp_dco;
    bit exp_mv;
    int exp_mc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int v, prev_dco, run, minrun, runs;
    bit dco_h;
    int act_h, mc_h;

    tbl[0] = '{1,   1'b0, 1'b0, 0};
    tbl[1] = '{127, 1'b0, 1'b0, 0};
    tbl[2] = '{128, 1'b1, 1'b0, 0};
    tbl[3] = '{255, 1'b1, 1'b0, 0};
    tbl[4] = '{256, 1'b0, 1'b1, 1};
    tbl[5] = '{257, 1'b0, 1'b0, 1};
    tbl[6] = '{384, 1'b1, 1'b0, 1};
    tbl[7] = '{512, 1'b0, 1'b1, 1};

    rst_n = 1'b0; ena = 1'b1; mode = 2'd0; code_valid = 1'b0; code_in = 8'd0;
    do_reset(3);
    check("reset_dco", int'(dco_out), 0);
    check("reset_active", int'(active_code), 0);
    check("reset_ready", int'(code_ready), 1);
    check("reset_mc", int'(meas_count), 0);
    check("reset_mv", int'(meas_valid), 0);

    // Code 0, inc 1: 128 low / 128 high, one rising edge per window.
    for (int i = 0; i < 8; i++) begin
      while (edge_no < tbl[i].edges) step();
      check("tbl_dco", int'(dco_out), int'(tbl[i].exp_dco));
      check("tbl_mv", int'(meas_valid), int'(tbl[i].exp_mv));
      check("tbl_mc", int'(meas_count), tbl[i].exp_mc);
    end

    // Code 127: applied at a wrap, ready returns one cycle later, toggles every clk.
    send_code(127);
    wait_active_change(v);
    check("apply_127", v, 127);
    check("ready_low_at_apply", int'(code_ready), 0);
    step();
    check("ready_back_after_apply", int'(code_ready), 1);
    prev_dco = int'(dco_out);
    for (int i = 0; i < 6; i++) begin
      step();
      check("dco_toggle", int'(dco_out), 1 - prev_dco);
      prev_dco = int'(dco_out);
    end
    wait_mv(); wait_mv();
    check("mc_code127", int'(meas_count), 128);

    // Code 255 clamps to the same increment as 127.
    send_code(255);
    wait_active_change(v);
    check("apply_255", v, 255);
    wait_mv(); wait_mv();
    check("mc_code255_clamped", int'(meas_count), 128);

    // Fast (inc 4) to slow (inc 2) switch mid-period: no pulse shorter than 32.
    send_code(3);
    wait_active_change(v);
    check("apply_3", v, 3);
    repeat (20) step();
    send_code(1);
    prev_dco = int'(dco_out); run = 0; minrun = 1000; runs = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (int'(dco_out) == prev_dco) run++;
      else begin
        if (runs > 0 && run + 1 < minrun) minrun = run + 1;
        runs++; run = 0; prev_dco = int'(dco_out);
      end
    end
    check("switch_applied", int'(active_code), 1);
    check("no_runt_pulse", (minrun >= 32) ? 1 : 0, 1);

    // Slew 0 -> 16 in steps of 4, ready held low until the target is reached.
    do_reset(1);
    mode = 2'd1;
    send_code(16);
    for (int i = 0; i < 4; i++) begin
      wait_active_change(v);
      check("slew_value", v, 4 * (i + 1));
      check("slew_ready_low", int'(code_ready), 0);
    end
    step();
    check("slew_ready_back", int'(code_ready), 1);

    // Freeze holds the pending code until the mode leaves freeze.
    mode = 2'd2;
    send_code(40);
    repeat (600) step();
    check("freeze_hold", int'(active_code), 16);
    check("freeze_pending", int'(code_ready), 0);
    mode = 2'd0;
    wait_active_change(v);
    check("unfreeze_apply", v, 40);

    // Reset mid-slew and mid-window discards the pending target.
    do_reset(1);
    mode = 2'd1;
    send_code(100);
    wait_active_change(v);
    wait_active_change(v);
    check("slew_mid", v, 8);
    repeat (13) step();
    rst_n = 1'b0;
    step();
    check("rst_mid_dco", int'(dco_out), 0);
    check("rst_mid_active", int'(active_code), 0);
    check("rst_mid_ready", int'(code_ready), 1);
    check("rst_mid_mc", int'(meas_count), 0);
    check("rst_mid_mv", int'(meas_valid), 0);
    rst_n = 1'b1;
    edge_no = 0;
    repeat (300) step();
    check("target_discarded", int'(active_code), 0);
    mode = 2'd0;

    // ena low for 50 cycles delays the window by exactly 50 cycles.
    do_reset(1);
    while (edge_no < 100) step();
    dco_h = dco_out; act_h = int'(active_code); mc_h = int'(meas_count);
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check("hold_dco", int'(dco_out), int'(dco_h));
      check("hold_active", int'(active_code), act_h);
      check("hold_mc", int'(meas_count), mc_h);
      check("hold_mv", int'(meas_valid), 0);
    end
    ena = 1'b1;
    wait_mv();
    check("mv_delay", edge_no, 306);
    check("mc_after_hold", int'(meas_count), 1);

    // Random traffic against the model.
    do_reset(2);
    for (int i = 0; i < 5000; i++) begin
      ena = ($urandom_range(15) != 0);
      if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
      if (!code_valid || code_ready) begin
        code_valid = ($urandom_range(7) == 0);
        code_in = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
      end
      rst_n = ($urandom_range(1999) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
